ysyx_22050854_regfile_mp: RTL and testbench
===========================================

// Module: ysyx_22050854_regfile_mp
// PURPOSE
//   Parametrised multi-port integer register file with write->read bypass and a per-register
//   pending-write scoreboard. Serves the decode stage: N read ports for operands, M writeback
//   ports, and one debug read port for difftest. Scoreboard busy bits let decode stall on RAW hazards.
// PARAMETERS
//   XLEN     64  data width of each register
//   NREGS    32  number of architectural registers (power of 2); AW = $clog2(NREGS)
//   NRD      2   number of read ports
//   NWR      1   number of write ports
//   BYPASS   1   1: same-cycle write data forwarded to read ports; 0: reads see array only
// PORTS
//   clk        in   1          system clock, rising edge
//   rst        in   1          asynchronous reset, active-high
//   wen        in   NWR        per-port write enable
//   waddr      in   NWR*AW     write addresses, port k at [k*AW +: AW]
//   wdata      in   NWR*XLEN   write data, port k at [k*XLEN +: XLEN]
//   raddr      in   NRD*AW     read addresses, port j at [j*AW +: AW]
//   rdata      out  NRD*XLEN   read data, combinational
//   rbusy      out  NRD        scoreboard busy bit of raddr[j] (after same-cycle clear)
//   iss_valid  in   1          instruction issued that will write iss_rd
//   iss_rd     in   AW         destination register of issued instruction
//   flush      in   1          pipeline flush: clear every busy bit
//   dbg_addr   in   AW         debug/difftest read address
//   dbg_data   out  XLEN       debug read data, array contents only (no bypass)
// BEHAVIOUR
//   - Reset (async, rst=1): all registers := 0, all busy bits := 0; outputs follow (rdata=0, rbusy=0).
//   - Register 0: always reads 0, never busy; writes and issues to addr 0 ignored.
//   - Write: on posedge clk, if wen[k] && waddr[k]!=0, reg[waddr[k]] := wdata[k]; visible in array next cycle.
//   - Same-address multi-write in one cycle: highest-index port wins (array and bypass alike).
//   - Read: rdata[j] = 0 if raddr[j]==0; else, if BYPASS && some wen[k] with waddr[k]==raddr[j],
//     wdata of highest such k; else reg[raddr[j]]. Pure combinational, zero latency.
//   - Scoreboard, per reg r!=0, updated posedge clk:
//       set   = iss_valid && iss_rd==r && !flush
//       clear = flush || (any wen[k] && waddr[k]==r)
//       busy[r] := set ? 1 : clear ? 0 : busy[r]   (set beats writeback clear: new producer)
//   - flush clears all busy bits; flush and iss_valid in the same cycle: issue dropped.
//   - rbusy[j] = busy[raddr[j]] && !(BYPASS && writeback to raddr[j] this cycle); 0 for addr 0.
//   - Register data is not affected by flush; only rst clears data.
//   - Reset asserted mid-write: write lost, state is reset value; first write after
//     rst deassert takes effect on the first clk edge with rst=0.
// STRUCTURE
//   - Package ysyx_22050854_rf_pkg: XLEN/NREGS defaults, AW derivation function, REG_ZERO constant.
//   - Sub-module ysyx_22050854_rf_scoreboard: busy vector, set/clear/flush logic, rbusy lookup.
//   - Top: storage array, write-priority decode, bypass muxes (generate over NRD), debug port.
// TESTING
//   1 Reset: write x5=0xDEAD, assert rst async mid-cycle -> rdata/dbg_data of x5 = 0 immediately, rbusy=0.
//   2 x0: wen=1 waddr=0 wdata=0xFFFF..., iss_rd=0 -> rdata(x0)=0, rbusy(x0)=0 all cycles.
//   3 Bypass: wen waddr=7 wdata=0x1234 with raddr0=7 same cycle -> rdata0=0x1234, dbg_data(x7)=old
//     value until next edge, then 0x1234; BYPASS=0 build -> rdata0=old value that cycle.
//   4 Dual write NWR=2: both ports waddr=3, data 0xA / 0xB -> rdata(x3)=0xB, array x3=0xB.
//   5 Scoreboard: issue rd=9 -> rbusy(x9)=1 next cycle; writeback x9 with new issue rd=9 same cycle
//     -> stays busy; writeback alone -> rbusy same cycle 0 (BYPASS=1), busy cleared next cycle.
//   6 Flush: busy x4,x8 set; flush with iss_valid rd=12 -> all busy 0 next cycle, x12 not busy.

Source files
------------

// File: rtl/ysyx_22050854_rf_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
// The address width is derived from the register count.
package ysyx_22050854_rf_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int REG_ZERO  = 0;

    function automatic int addr_width(input int nregs);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < nregs) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/ysyx_22050854_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue and cleared on writeback or flush.
// rbusy reports each read port's busy bit, with this cycle's writeback already taken into account.
module ysyx_22050854_rf_scoreboard
    import ysyx_22050854_rf_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    parameter int AW     = addr_width(NREGS_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NRD*AW-1:0] raddr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    output logic [NRD-1:0]    rbusy
);

    logic [NREGS-1:0] busy;

    assign busy[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_busy
            logic set_b;
            logic clr_b;
            logic busy_reg;

            always_comb begin
                set_b = iss_valid && (iss_rd == AW'(gi)) && !flush;
                clr_b = flush;
                for (int k = 0; k < NWR; k++) begin
                    if (wen[k] && (waddr[k*AW +: AW] == AW'(gi))) begin
                        clr_b = 1'b1;
                    end
                end
            end

            // A new issue wins over a writeback in the same cycle: it names a newer producer.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    busy_reg <= 1'b0;
                end else if (set_b) begin
                    busy_reg <= 1'b1;
                end else if (clr_b) begin
                    busy_reg <= 1'b0;
                end
            end

            assign busy[gi] = busy_reg;
        end

        for (gi = 0; gi < NRD; gi++) begin : g_rbusy
            logic [AW-1:0] ra;
            logic          wb_hit;

            assign ra = raddr[gi*AW +: AW];

            always_comb begin
                wb_hit = 1'b0;
                for (int k = 0; k < NWR; k++) begin
                    if (wen[k] && (waddr[k*AW +: AW] == ra)) begin
                        wb_hit = 1'b1;
                    end
                end
            end

            assign rbusy[gi] = busy[ra] && !((BYPASS != 0) && wb_hit);
        end
    endgenerate

endmodule

// File: rtl/ysyx_22050854_regfile_mp.sv
// Multi-port integer register file with optional write->read bypass, a debug read port
// and a pending-write scoreboard for decode-stage RAW stalls.
module ysyx_22050854_regfile_mp
    import ysyx_22050854_rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    logic [XLEN-1:0] regs [NREGS];

    assign regs[0] = '0;

    genvar gi;
    generate
        // Each register picks its own write port; scanning upward lets the highest port win.
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic            wr_hit;
            logic [XLEN-1:0] wr_data;
            logic [XLEN-1:0] data_reg;

            always_comb begin
                wr_hit  = 1'b0;
                wr_data = '0;
                for (int k = 0; k < NWR; k++) begin
                    if (wen[k] && (waddr[k*AW +: AW] == AW'(gi))) begin
                        wr_hit  = 1'b1;
                        wr_data = wdata[k*XLEN +: XLEN];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (wr_hit) begin
                    data_reg <= wr_data;
                end
            end

            assign regs[gi] = data_reg;
        end

        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   ra;
            logic            fwd_hit;
            logic [XLEN-1:0] fwd_data;
            logic [XLEN-1:0] rd_val;

            assign ra = raddr[gi*AW +: AW];

            always_comb begin
                fwd_hit  = 1'b0;
                fwd_data = '0;
                for (int k = 0; k < NWR; k++) begin
                    if (wen[k] && (waddr[k*AW +: AW] == ra)) begin
                        fwd_hit  = 1'b1;
                        fwd_data = wdata[k*XLEN +: XLEN];
                    end
                end
                if (ra == AW'(REG_ZERO)) begin
                    rd_val = '0;
                end else if ((BYPASS != 0) && fwd_hit) begin
                    rd_val = fwd_data;
                end else begin
                    rd_val = regs[ra];
                end
            end

            assign rdata[gi*XLEN +: XLEN] = rd_val;
        end
    endgenerate

    assign dbg_data = regs[dbg_addr];

    ysyx_22050854_rf_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS),
        .AW     (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .waddr     (waddr),
        .raddr     (raddr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .rbusy     (rbusy)
    );

endmodule

// File: tb/tb_ysyx_22050854_regfile_mp.sv
// Directed and random stimulus for the register file, checked against an array/scoreboard model.
// Two instances share stimulus: one with bypass, one reading the array only.
module tb_ysyx_22050854_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata, rdata_nb;
    logic [NRD-1:0]      rbusy, rbusy_nb;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data, dbg_data_nb;

    logic [XLEN-1:0] mregs [NREGS];
    logic            mbusy [NREGS];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ysyx_22050854_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata), .rbusy(rbusy), .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    ysyx_22050854_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_nb), .rbusy(rbusy_nb), .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read: x0 is zero, otherwise the last matching writer (if bypassing) or the stored value.
    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        v = mregs[a];
        if (byp) begin
            for (int k = 0; k < NWR; k++)
                if (wen[k] && waddr[k*AW +: AW] == a) v = wdata[k*XLEN +: XLEN];
        end
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        logic b;
        if (a == 0) return 1'b0;
        b = mbusy[a];
        if (byp) begin
            for (int k = 0; k < NWR; k++)
                if (wen[k] && waddr[k*AW +: AW] == a) b = 1'b0;
        end
        return b;
    endfunction

    task automatic check_all(input string phase);
        for (int j = 0; j < NRD; j++) begin
            logic [AW-1:0] a;
            a = raddr[j*AW +: AW];
            check($sformatf("%s rdata%0d x%0d", phase, j, a), rdata[j*XLEN +: XLEN], exp_rd(a, 1'b1));
            check($sformatf("%s nb_rdata%0d x%0d", phase, j, a), rdata_nb[j*XLEN +: XLEN], exp_rd(a, 1'b0));
            check($sformatf("%s rbusy%0d x%0d", phase, j, a), {63'b0, rbusy[j]}, {63'b0, exp_busy(a, 1'b1)});
            check($sformatf("%s nb_rbusy%0d x%0d", phase, j, a), {63'b0, rbusy_nb[j]}, {63'b0, exp_busy(a, 1'b0)});
        end
        check($sformatf("%s dbg x%0d", phase, dbg_addr), dbg_data, mregs[dbg_addr]);
        check($sformatf("%s nb_dbg x%0d", phase, dbg_addr), dbg_data_nb, mregs[dbg_addr]);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            mregs[r] = '0;
            mbusy[r] = 1'b0;
        end
    endtask

    // Advance one clock edge, applying the architectural rules to the model.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < NWR; k++)
                if (wen[k] && waddr[k*AW +: AW] != 0) mregs[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
            if (flush) for (int r = 0; r < NREGS; r++) mbusy[r] = 1'b0;
            for (int k = 0; k < NWR; k++)
                if (wen[k]) mbusy[waddr[k*AW +: AW]] = 1'b0;
            if (iss_valid && !flush && iss_rd != 0) mbusy[iss_rd] = 1'b1;
            mbusy[0] = 1'b0;
        end
        #1;
    endtask

    // Called just after a rising edge: check mid-cycle, print the transaction, then clock it in.
    task automatic cycle(input string phase);
        #4;
        check_all(phase);
        $display("cyc %0d %s wen=%b waddr=%h raddr=%h iss=%b/%0d flush=%b rbusy=%b",
                 cyc, phase, wen, waddr, raddr, iss_valid, iss_rd, flush, rbusy);
        cyc++;
        tick();
    endtask

    task automatic set_wr(input int k, input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wen[k] = en;
        waddr[k*AW +: AW] = a;
        wdata[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int j, input logic [AW-1:0] a);
        raddr[j*AW +: AW] = a;
    endtask

    task automatic idle();
        wen = '0; waddr = '0; wdata = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    initial begin
        idle();
        raddr = '0;
        dbg_addr = '0;
        model_reset();

        // Reset state
        #12;
        set_rd(0, 5'd5); set_rd(1, 5'd9); dbg_addr = 5'd5;
        #1;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: write x5, then async reset mid-cycle
        set_wr(0, 1'b1, 5'd5, 64'hDEAD);
        iss_valid = 1'b1; iss_rd = 5'd9;
        cycle("t1_write");
        idle();
        cycle("t1_after");
        #2; rst = 1'b1; model_reset(); #1;
        check_all("t1_async_rst");
        set_wr(0, 1'b1, 5'd5, 64'hBEEF);
        @(posedge clk); #1;
        check("t1_write_lost dbg", dbg_data, 64'h0);
        #2; rst = 1'b0;
        cycle("t1_first_write");
        idle();
        cycle("t1_first_write_seen");

        // 2: x0 never written, never busy
        set_wr(0, 1'b1, 5'd0, '1); set_wr(1, 1'b1, 5'd0, '1);
        iss_valid = 1'b1; iss_rd = 5'd0;
        set_rd(0, 5'd0); set_rd(1, 5'd0); dbg_addr = 5'd0;
        cycle("t2_x0_a");
        cycle("t2_x0_b");
        idle();
        cycle("t2_x0_c");

        // 3: bypass vs array-only read
        set_wr(0, 1'b1, 5'd7, 64'h55);
        cycle("t3_pre");
        set_wr(0, 1'b1, 5'd7, 64'h1234);
        set_rd(0, 5'd7); dbg_addr = 5'd7;
        cycle("t3_bypass");
        idle();
        cycle("t3_after");
        check("t3 dbg x7", dbg_data, 64'h1234);

        // 4: two ports to the same register, higher port wins
        set_wr(0, 1'b1, 5'd3, 64'hA); set_wr(1, 1'b1, 5'd3, 64'hB);
        set_rd(1, 5'd3); dbg_addr = 5'd3;
        cycle("t4_dual");
        idle();
        cycle("t4_after");
        check("t4 dbg x3", dbg_data, 64'hB);

        // 5: scoreboard set / writeback with reissue / writeback alone
        set_rd(0, 5'd9);
        iss_valid = 1'b1; iss_rd = 5'd9;
        cycle("t5_issue");
        idle();
        cycle("t5_busy");
        check("t5 rbusy x9", {63'b0, rbusy[0]}, 64'h1);
        set_wr(0, 1'b1, 5'd9, 64'h99); iss_valid = 1'b1; iss_rd = 5'd9;
        cycle("t5_wb_reissue");
        idle();
        cycle("t5_still_busy");
        set_wr(0, 1'b1, 5'd9, 64'h9A);
        cycle("t5_wb_only");
        idle();
        cycle("t5_cleared");

        // 6: flush drops all busy bits and the same-cycle issue
        iss_valid = 1'b1; iss_rd = 5'd4;
        cycle("t6_iss4");
        iss_rd = 5'd8;
        set_rd(0, 5'd4); set_rd(1, 5'd8);
        cycle("t6_iss8");
        iss_rd = 5'd12; flush = 1'b1;
        cycle("t6_flush");
        idle();
        cycle("t6_after_a");
        set_rd(0, 5'd12);
        cycle("t6_after_b");

        // Random traffic over a narrow address range to force collisions
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NWR; k++)
                set_wr(k, 1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 11)),
                       {$urandom, $urandom});
            for (int j = 0; j < NRD; j++) set_rd(j, AW'($urandom_range(0, 11)));
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd = AW'($urandom_range(0, 11));
            flush = 1'($urandom_range(0, 19) == 0);
            dbg_addr = AW'($urandom_range(0, 11));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
